// File: rtl/sync_filter_pkg.sv
// sync_pkg: shared helpers for the sync_filter slice.
//   clog2     - ceiling log2, used to size the per-bit filter counters
//   popcount  - number of set bits, used by the optional gray jump check
//   SYNC_MIN_STAGES / SYNC_MAX_STAGES - legal synchroniser chain depths
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_filter_bit_filter.sv
// sync_bit_filter: single-bit consecutive-cycle glitch filter with
// registered rise/fall pulse generation, in the destination clock domain.
//   clk_i  - destination clock (rising edge)
//   rst_i  - synchronous active-high reset
//   s_i    - bit from the end of the synchroniser chain
//   data_o - filtered bit (RST_VAL on reset)
//   rise_o - one-cycle pulse in the cycle data_o shows a 0->1 change
//   fall_o - one-cycle pulse in the cycle data_o shows a 1->0 change
// FILTER = 0 bypasses the counter: data_o simply registers s_i.
module sync_bit_filter
  import sync_pkg::*;
#(
  parameter int   FILTER  = 0,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic s_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (clog2(FILTER + 1) < 1) ? 1 : clog2(FILTER + 1);

  logic data_q, data_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  if (FILTER == 0) begin : g_bypass
    always_comb data_d = s_i;
  end else begin : g_filter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only ever runs while s_i disagrees with the output; any
    // agreeing cycle clears it, so a short pulse leaves no residue and the
    // count tops out at FILTER-1 before the output switches.
    always_comb begin
      data_d = data_q;
      cnt_d  = '0;
      if (s_i == data_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(FILTER - 1)) begin
        data_d = s_i;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

  // Pulses are computed from the next output value so they land in the
  // same cycle the output shows its new level.
  always_comb begin
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data_o = data_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sync_filter.sv
// sync_filter: parametrised multi-bit, multi-stage synchroniser with an
// optional per-bit glitch filter and registered rise/fall pulses.
//   clk_i        - destination clock (rising edge)
//   rst_i        - synchronous active-high reset
//   async_data_i - asynchronous input bits (WIDTH)
//   sync_data_o  - synchronised / filtered data (WIDTH)
//   rise_o       - per-bit 0->1 pulse (WIDTH)
//   fall_o       - per-bit 1->0 pulse (WIDTH)
//   gray_err_o   - multi-bit jump pulse at the chain output
// Optional feature macro: SYNC_FILTER_GRAY_CHK_EN enables the gray jump
// check; without it gray_err_o is constant 0 and no extra flops exist.
module sync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH   = 6,
  parameter int               STAGES  = 2,
  parameter int               FILTER  = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_data_i,
  output logic [WIDTH-1:0] sync_data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             gray_err_o
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_filter: STAGES must be in 2..4");
  end

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];
  logic [WIDTH-1:0] s;

  always_comb begin
    chain_d[0] = async_data_i;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= chain_d[i];
    end
  end

  assign s = chain_q[STAGES-1];

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    sync_bit_filter #(
      .FILTER (FILTER),
      .RST_VAL(RST_VAL[b])
    ) u_filter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .s_i   (s[b]),
      .data_o(sync_data_o[b]),
      .rise_o(rise_o[b]),
      .fall_o(fall_o[b])
    );
  end

`ifdef SYNC_FILTER_GRAY_CHK_EN
  logic [WIDTH-1:0] prev_s_q, prev_s_d;
  logic             gray_err_q, gray_err_d;

  // The check looks at the raw chain output, ahead of any filtering, so a
  // non-gray jump is flagged regardless of FILTER.
  always_comb begin
    prev_s_d   = s;
    gray_err_d = (popcount(64'(s ^ prev_s_q)) > 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_s_q   <= '0;
      gray_err_q <= 1'b0;
    end else begin
      prev_s_q   <= prev_s_d;
      gray_err_q <= gray_err_d;
    end
  end

  assign gray_err_o = gray_err_q;
`else
  assign gray_err_o = 1'b0;
`endif

endmodule
